// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
//   Multiply uses a shift-add loop, divide a restoring loop, one bit per cycle.
//   Divide-by-zero and signed-overflow divides complete on a single-cycle fast path.
// Ports:
//   clk_i     clock, rising edge
//   rst_i     synchronous active-high reset
//   start_i   request, honoured only in IDLE or DONE
//   op_i      RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   srca_i    rs1 (multiplicand / dividend)
//   srcb_i    rs2 (multiplier / divisor)
//   flush_i   abort the in-flight operation
//   busy_o    high while iterating (CALC) or correcting (FIX)
//   done_o    one-cycle pulse, result_o valid
//   result_o  result, held until the next accepted start
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] srca_i,
  input  logic [DATA_WIDTH-1:0] srcb_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt;
  logic [2:0]     op_q;
  logic           neg_main;   // negate product / quotient
  logic           neg_rem;    // negate remainder (dividend sign)
  logic [W-1:0]   opnd;       // multiplicand or divisor magnitude
  logic [W:0]     hi;         // upper product half / partial remainder
  logic [W-1:0]   lo;         // multiplier shifting out / quotient shifting in

  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] x, input logic n);
    return n ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] x, input logic sgn);
    return cond_neg(x, sgn && (x < 0));
  endfunction

  // ---------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------
  logic signed [W-1:0] srca_s, srcb_s;
  logic         sign_a, sign_b, neg_a, neg_b;
  logic         is_div, is_rem, signed_div, b_zero, ovf, special, accept;
  logic [W-1:0] special_res, mag_a, mag_b;

  always_comb begin
    srca_s      = srca_i;
    srcb_s      = srcb_i;
    is_div      = op_i[2];
    is_rem      = op_i[2] & op_i[1];
    signed_div  = op_i[2] & ~op_i[0];
    // MULHSU treats only rs1 as signed
    sign_a      = (op_i == 3'b001) || (op_i == 3'b010) || signed_div;
    sign_b      = (op_i == 3'b001) || signed_div;
    neg_a       = sign_a && (srca_s < 0);
    neg_b       = sign_b && (srcb_s < 0);
    mag_a       = magnitude(srca_s, sign_a);
    mag_b       = magnitude(srcb_s, sign_b);
    b_zero      = (srcb_i == '0);
    ovf         = signed_div && (srca_i == MOST_NEG) && (srcb_i == '1);
    special     = is_div && (b_zero || ovf);
    special_res = '0;
    if (b_zero)
      special_res = is_rem ? srca_i : '1;
    else
      special_res = is_rem ? '0 : MOST_NEG;
    accept      = start_i && !flush_i && ((state == IDLE) || (state == DONE));
  end

  // ---------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy_o  = (state == CALC) || (state == FIX);
    done_o  = (state == DONE);
    if (flush_i) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) state_n = special ? DONE : CALC;
          else        state_n = IDLE;
        end
        CALC:    if (cnt == '0) state_n = FIX;
        FIX:     state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Iteration step
  // ---------------------------------------------------------------
  logic [W:0]   mul_sum, div_shift;
  logic [W+1:0] div_diff;
  logic         div_ok;
  logic [W:0]   hi_n;
  logic [W-1:0] lo_n;

  always_comb begin
    mul_sum   = hi + (lo[0] ? {1'b0, opnd} : '0);
    div_shift = {hi[W-1:0], lo[W-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    div_ok    = ~div_diff[W+1];
    if (op_q[2]) begin
      hi_n = div_ok ? div_diff[W:0] : div_shift;
      lo_n = {lo[W-2:0], div_ok};
    end else begin
      hi_n = {1'b0, mul_sum[W:1]};
      lo_n = {mul_sum[0], lo[W-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q     <= op_i;
      opnd     <= op_i[2] ? mag_b : mag_a;
      lo       <= op_i[2] ? mag_a : mag_b;
      hi       <= '0;
      neg_main <= neg_a ^ neg_b;
      neg_rem  <= neg_a;
    end else if (state == CALC) begin
      hi <= hi_n;
      lo <= lo_n;
    end
  end

  // ---------------------------------------------------------------
  // Sign correction and result select
  // ---------------------------------------------------------------
  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]   fix_res;

  always_comb begin
    prod     = {hi[W-1:0], lo};
    prod_fix = neg_main ? (~prod + 1'b1) : prod;
    case (op_q)
      3'b000:                 fix_res = prod_fix[W-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*W-1:W];
      3'b100, 3'b101:         fix_res = cond_neg(lo, neg_main);
      default:                fix_res = cond_neg(hi[W-1:0], neg_rem);
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt      <= '0;
      result_o <= '0;
    end else if (!flush_i) begin
      if (accept) begin
        cnt <= CW'(W - 1);
        if (special) result_o <= special_res;
      end else if (state == CALC) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
      end else if (state == FIX) begin
        result_o <= fix_res;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized bench for muldiv_unit (DATA_WIDTH=32),
// checked against a plain-arithmetic RV32M reference model.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [2:0]   op;
  logic [W-1:0] srca, srcb;
  logic         busy, done;
  logic [W-1:0] result;
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] last_res;

  always #5 clk = ~clk;

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
    .srca_i(srca), .srcb_i(srcb), .flush_i(flush),
    .busy_o(busy), .done_o(done), .result_o(result)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == MIN && b == '1) return MIN;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return '1;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN && b == '1) return '0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    return f[2] && ((b == 0) || ((f == 3'd4 || f == 3'd6) && a == MIN && b == '1));
  endfunction

  // Called just after a negedge in a cycle where the unit can accept.
  // Returns at the negedge where done_o is seen (or when the bound expires).
  task automatic do_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output int lat, output int nbusy);
    op = f; srca = a; srcb = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    srca = $urandom; srcb = $urandom; op = 3'($urandom);
    lat = 0; nbusy = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
      if (done) break;
    end
    res = result;
  endtask

  task automatic run_chk(input string tag, input logic [2:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp);
    logic [W-1:0] res;
    int lat, nbusy;
    bit sp;
    sp = is_special(f, a, b);
    do_op(f, a, b, res, lat, nbusy);
    chk({tag, "_res"},  res,   exp);
    chk({tag, "_lat"},  lat,   sp ? 1 : 34);
    chk({tag, "_busy"}, nbusy, sp ? 0 : 33);
    last_res = exp;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return MIN;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n_done, n_busy;
    logic [2:0] f;
    logic [W-1:0] a, b;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; srca = '0; srcb = '0;
    last_res = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", result, 0);
    rst = 1'b0;
    @(negedge clk);

    run_chk("mul",    3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_chk("mulh",   3'd1, MIN, MIN, 32'h4000_0000);
    run_chk("mulhu",  3'd3, '1, '1, 32'hFFFF_FFFE);
    run_chk("mulhsu", 3'd2, '1, 32'd2, 32'hFFFF_FFFF);
    run_chk("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_chk("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_chk("divu",   3'd5, 32'd100, 32'd7, 32'd14);
    run_chk("remu",   3'd7, 32'd100, 32'd7, 32'd2);
    run_chk("divu0",  3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_chk("remu0",  3'd7, 32'd5, 32'd0, 32'd5);
    run_chk("divovf", 3'd4, MIN, '1, MIN);
    run_chk("removf", 3'd6, MIN, '1, 32'd0);

    // single-cycle done pulse and held result while idle
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_hold", result, last_res);

    // back-to-back: second start issued in the DONE cycle
    run_chk("b2b_mul", 3'd0, 32'd3, 32'd4, 32'd12);
    run_chk("b2b_div", 3'd4, 32'd20, 32'd3, 32'd6);

    // flush 10 cycles into a divide
    op = 3'd4; srca = 32'd1000; srcb = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    chk("flush_pre_busy", busy, 1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_res", result, last_res);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("flush_nodone", n_done, 0);

    // flush together with start in IDLE: nothing accepted
    op = 3'd0; srca = 32'd9; srcb = 32'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    n_done = 0; n_busy = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
      if (busy) n_busy++;
    end
    chk("flstart_busy", n_busy, 0);
    chk("flstart_done", n_done, 0);
    chk("flstart_res", result, last_res);

    // reset in the middle of CALC
    op = 3'd0; srca = 32'd11; srcb = 32'd13; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_res", result, 0);
    run_chk("post_rst_mul", 3'd0, 32'd6, 32'd7, 32'd42);

    // randomized operations against the reference model
    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom);
      a = pick();
      b = pick();
      run_chk("rand", f, a, b, ref_model(f, a, b));
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        chk("rand_pulse", done, 0);
        chk("rand_hold", result, last_res);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
